ball_motion: RTL and testbench
==============================

# ball_motion

Frame-rate ball integrator and game-state keeper that sits directly downstream of the collision stage. It consumes the collision stage's velocity (`dx`, `dy`), per-brick hit flags and `game_over`, and produces the registered ball position that is fed back to collision and to the renderer. It also keeps the brick-alive mask, the score and the serve/play/over state machine.

## Interface
- `START_X`, default 309: ball x on serve/reset.
- `START_Y`, default 400: ball y on serve/reset.
- `X_MIN`, default 133: minimum ball_x (left wall).
- `X_MAX`, default 485: maximum ball_x (right wall 505 minus ball width 20).
- `Y_MAX`, default 439: maximum ball_y (floor 459 minus ball height 20); the minimum is 0.
- `SERVE_FRAMES`, default 120: frames in SERVE before auto-launch.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-low reset.
- `frame_tick`, in, 1: one-cycle pulse, once per video frame.
- `launch`, in, 1: player button, level.
- `dx`, in, 4: x velocity, two's complement (-8..+7) px/frame.
- `dy`, in, 4: y velocity, two's complement.
- `brick_hit`, in, 6: bit i = collision brick(i+1) flag.
- `game_over`, in, 1: from collision stage.
- `ball_x`, out, 9: registered ball x.
- `ball_y`, out, 9: registered ball y.
- `brick_alive`, out, 6: bit i = brick i still present.
- `score`, out, 8: bricks destroyed, saturating.
- `state`, out, 2: 0 SERVE, 1 PLAY, 2 OVER.
- `win`, out, 1: high in OVER when all bricks were cleared.

## Operation
- Reset (rst==0 at a clk edge) forces the following values:
  - ball_x=START_X, ball_y=START_Y
  - brick_alive=6'b111111, score=0
  - state=SERVE, win=0
  - serve frame counter=0, hit history register=0
- SERVE:
  - Position is held at START.
  - The counter increments on each frame_tick.
  - Transition to PLAY on `launch`==1 or when the counter reaches SERVE_FRAMES-1 on a frame_tick, whichever comes first.
  - brick_hit and game_over are ignored in this state.
- PLAY, on frame_tick:
  - The sign-extended dx/dy is added in 10-bit signed arithmetic.
  - The result is clamped: x to [X_MIN, X_MAX], y to [0, Y_MAX]. A negative sum clamps to the minimum; it never wraps.
- PLAY, brick hits:
  - A rising edge on brick_hit[i] (prev 0, now 1) with brick_alive[i]==1 clears brick_alive[i].
  - score increases by the popcount of such edges in that cycle, saturating at 255.
  - A held-high flag counts once. A hit on a dead brick is ignored.
- PLAY, exits:
  - PLAY -> OVER with win=0 when game_over==1.
  - PLAY -> OVER with win=1 when brick_alive becomes 0; the transition takes effect in the cycle after the last bit clears.
- OVER:
  - Position, mask and score are frozen; frame_tick is ignored.
  - A rising edge of `launch` goes to SERVE. This reloads position and mask, clears score, win and the counter.
- The launch edge detector is a registered copy of `launch`. Because of it, a button held from SERVE through OVER does not immediately re-serve.

## Timing
- All outputs are registered. The new position is visible in the cycle after the frame_tick cycle (1-cycle latency).
- The brick_alive and score update is visible 1 cycle after the brick_hit edge is sampled.
- Simultaneous events in PLAY:
  - game_over with frame_tick: the transition to OVER wins and the position is not updated.
  - Brick edge with frame_tick: both are applied in the same cycle.
  - game_over with a brick edge: the brick clear and score are applied, state goes to OVER, and win=0.
- `launch` with frame_tick at the SERVE terminal count: PLAY is entered once; the first move happens on the next frame_tick.
- rst low in any state, mid-frame, overrides everything on that edge.

## Test plan
1. Reset, then SERVE count:
   - Stimulus: hold rst=0 two cycles, release, then issue 120 frame_ticks with no launch.
   - Response: ball stays at (309,400), mask=0x3F, score=0; state goes to PLAY after tick 120.
2. Move and clamp:
   - Stimulus: in PLAY at (309,400) with dx=+3, dy=-2 (4'hE), one frame_tick.
   - Response: ball at (312,398) one cycle later.
   - Stimulus: from ball_x=484 with dx=+7, one frame_tick.
   - Response: ball_x=485. Similarly ball_y=1 with dy=-8 gives ball_y=0.
3. Brick edges:
   - Stimulus: brick_hit=6'b000101 held high 5 cycles.
   - Response: mask=0x3A, score=2, each counted once.
   - Stimulus: re-pulse bit 0.
   - Response: score stays 2.
4. Win:
   - Stimulus: hit all remaining bricks.
   - Response: mask=0, score=6, state=OVER, win=1. Later frame_ticks do not move the ball.
5. game_over priority:
   - Stimulus: game_over and frame_tick in the same cycle.
   - Response: OVER, position unchanged, win=0.
   - Stimulus: launch held through the transition, then released and pressed again.
   - Response: SERVE only on the new press, with score=0 and mask=0x3F.

Source files
------------

// File: rtl/ball_motion.sv
// Ball position integrator and game-state keeper.
// Tracks ball motion, brick mask, score and serve/play/over.
module ball_motion #(
  parameter int START_X      = 309,
  parameter int START_Y      = 400,
  parameter int X_MIN        = 133,
  parameter int X_MAX        = 485,
  parameter int Y_MAX        = 439,
  parameter int SERVE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [3:0] dx,
  input  logic [3:0] dy,
  input  logic [5:0] brick_hit,
  input  logic       game_over,
  output logic [8:0] ball_x,
  output logic [8:0] ball_y,
  output logic [5:0] brick_alive,
  output logic [7:0] score,
  output logic [1:0] state,
  output logic       win
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  state_t      st_q, st_d;
  logic [8:0]  x_d, y_d;
  logic [5:0]  alive_d;
  logic [7:0]  score_d;
  logic        win_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  hit_q;
  logic        launch_q;

  logic signed [9:0] x_sum, y_sum;
  logic [5:0]        new_hits;
  logic [2:0]        n_hits;
  logic [8:0]        s_sum;
  logic              launch_rise;

  assign state       = st_q;
  assign launch_rise = launch & ~launch_q;

  // Candidate position, brick edges and saturating score.
  always_comb begin
    x_sum = $signed({1'b0, ball_x}) + $signed({{6{dx[3]}}, dx});
    y_sum = $signed({1'b0, ball_y}) + $signed({{6{dy[3]}}, dy});
    new_hits = brick_hit & ~hit_q & brick_alive;
    n_hits = 3'd0;
    for (int i = 0; i < 6; i++) begin
      n_hits = n_hits + 3'(new_hits[i]);
    end
    s_sum = {1'b0, score} + 9'(n_hits);
  end

  // Next-state and next-output logic.
  always_comb begin
    st_d    = st_q;
    x_d     = ball_x;
    y_d     = ball_y;
    alive_d = brick_alive;
    score_d = score;
    win_d   = win;
    cnt_d   = cnt_q;
    unique case (st_q)
      SERVE: begin
        x_d = 9'(START_X);
        y_d = 9'(START_Y);
        if (launch ||
            (frame_tick &&
             cnt_q == 16'(SERVE_FRAMES - 1))) begin
          st_d  = PLAY;
          cnt_d = '0;
        end else if (frame_tick) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PLAY: begin
        alive_d = brick_alive & ~new_hits;
        score_d = s_sum[8] ? 8'hFF : s_sum[7:0];
        if (game_over) begin
          st_d  = OVER;
          win_d = 1'b0;
        end else if (brick_alive == 6'd0) begin
          st_d  = OVER;
          win_d = 1'b1;
        end else if (frame_tick) begin
          if (x_sum < $signed(10'(X_MIN)))
            x_d = 9'(X_MIN);
          else if (x_sum > $signed(10'(X_MAX)))
            x_d = 9'(X_MAX);
          else
            x_d = x_sum[8:0];
          if (y_sum < 10'sd0)
            y_d = 9'd0;
          else if (y_sum > $signed(10'(Y_MAX)))
            y_d = 9'(Y_MAX);
          else
            y_d = y_sum[8:0];
        end
      end
      OVER: begin
        if (launch_rise) begin
          st_d    = SERVE;
          x_d     = 9'(START_X);
          y_d     = 9'(START_Y);
          alive_d = 6'h3F;
          score_d = 8'd0;
          win_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: st_d = SERVE;
    endcase
  end

  // State, outputs and edge-detect history registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q        <= SERVE;
      ball_x      <= 9'(START_X);
      ball_y      <= 9'(START_Y);
      brick_alive <= 6'h3F;
      score       <= 8'd0;
      win         <= 1'b0;
      cnt_q       <= '0;
      hit_q       <= 6'd0;
      launch_q    <= 1'b0;
    end else begin
      st_q        <= st_d;
      ball_x      <= x_d;
      ball_y      <= y_d;
      brick_alive <= alive_d;
      score       <= score_d;
      win         <= win_d;
      cnt_q       <= cnt_d;
      hit_q       <= brick_hit;
      launch_q    <= launch;
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion.
// Random and directed stimulus against a behavioural game model.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       launch = 1'b0;
  logic [3:0] dx = 4'd0;
  logic [3:0] dy = 4'd0;
  logic [5:0] brick_hit = 6'd0;
  logic       game_over = 1'b0;
  logic [8:0] ball_x, ball_y;
  logic [5:0] brick_alive;
  logic [7:0] score;
  logic [1:0] state;
  logic       win;

  ball_motion dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .launch(launch), .dx(dx), .dy(dy),
    .brick_hit(brick_hit), .game_over(game_over),
    .ball_x(ball_x), .ball_y(ball_y),
    .brick_alive(brick_alive), .score(score),
    .state(state), .win(win)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       x;
    int       y;
    bit [5:0] alive;
    int       sc;
    int       st;
    bit       w;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 0;

  // model: game state in plain integers, modes 0 serve 1 play 2 over
  int       m_x, m_y, m_sc, m_st, m_cnt;
  bit [5:0] m_alive, m_prev_hit;
  bit       m_win, m_prev_la;

  task automatic model(input bit r, input bit ft,
                       input bit la, input int vx,
                       input int vy, input bit [5:0] h,
                       input bit g);
    bit [5:0] fresh;
    bit [5:0] was_alive;
    if (!r) begin
      m_x = 309; m_y = 400; m_alive = 6'h3F;
      m_sc = 0; m_st = 0; m_win = 0; m_cnt = 0;
      m_prev_hit = 0; m_prev_la = 0;
      return;
    end
    if (m_st == 0) begin
      m_x = 309; m_y = 400;
      if (la || (ft && m_cnt == 119)) begin
        m_st = 1; m_cnt = 0;
      end else if (ft) m_cnt++;
    end else if (m_st == 1) begin
      was_alive = m_alive;
      fresh = h & ~m_prev_hit & m_alive;
      m_alive = m_alive & ~fresh;
      m_sc = m_sc + $countones(fresh);
      if (m_sc > 255) m_sc = 255;
      if (g) begin
        m_st = 2; m_win = 0;
      end else if (was_alive == 0) begin
        m_st = 2; m_win = 1;
      end else if (ft) begin
        m_x = m_x + vx;
        m_y = m_y + vy;
        if (m_x < 133) m_x = 133;
        if (m_x > 485) m_x = 485;
        if (m_y < 0) m_y = 0;
        if (m_y > 439) m_y = 439;
      end
    end else begin
      if (la && !m_prev_la) begin
        m_st = 0; m_x = 309; m_y = 400;
        m_alive = 6'h3F; m_sc = 0; m_win = 0;
        m_cnt = 0;
      end
    end
    m_prev_hit = h;
    m_prev_la  = la;
  endtask

  task automatic step(input bit r, input bit ft,
                      input bit la, input logic [3:0] vdx,
                      input logic [3:0] vdy,
                      input logic [5:0] h, input bit g);
    exp_t e;
    rst = r; frame_tick = ft; launch = la;
    dx = vdx; dy = vdy; brick_hit = h; game_over = g;
    model(r, ft, la, int'($signed(vdx)),
          int'($signed(vdy)), h, g);
    e.x = m_x; e.y = m_y; e.alive = m_alive;
    e.sc = m_sc; e.st = m_st; e.w = m_win;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act,
                     input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, req);
    end
  endtask

  // monitor: compare every registered output after each edge
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (int'(ball_x) != e.x || int'(ball_y) != e.y ||
            brick_alive !== e.alive ||
            int'(score) != e.sc || int'(state) != e.st ||
            win !== e.w) begin
          n_fail++;
          $display("FAIL out @%0t: got x=%0d y=%0d m=%h s=%0d st=%0d w=%0b, expected x=%0d y=%0d m=%h s=%0d st=%0d w=%0b",
                   $time, ball_x, ball_y, brick_alive, score,
                   state, win, e.x, e.y, e.alive, e.sc, e.st,
                   e.w);
        end
      end
    end
  end

  initial begin
    bit r, ft, la, g;
    // reset and serve countdown
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_x", ball_x, 309);
    chk("rst_y", ball_y, 400);
    chk("rst_mask", brick_alive, 'h3F);
    chk("rst_score", score, 0);
    chk("rst_state", state, 0);
    chk("rst_win", win, 0);
    for (int i = 0; i < 120; i++) begin
      step(1, 1, 0, 4'd5, 4'd5, 6'h3F, 1);
      if (i == 118) chk("serve_119", state, 0);
      step(1, 0, 0, 0, 0, 0, 0);
    end
    chk("serve_120", state, 1);
    chk("serve_x", ball_x, 309);
    chk("serve_mask", brick_alive, 'h3F);
    // move and clamp
    step(1, 1, 0, 4'd3, 4'hE, 0, 0);
    chk("move_x", ball_x, 312);
    chk("move_y", ball_y, 398);
    for (int i = 0; i < 24; i++) step(1, 1, 0, 4'd7, 0, 0, 0);
    step(1, 1, 0, 4'd4, 0, 0, 0);
    chk("x_484", ball_x, 484);
    step(1, 1, 0, 4'd7, 0, 0, 0);
    chk("x_clamp", ball_x, 485);
    for (int i = 0; i < 49; i++) step(1, 1, 0, 0, 4'h8, 0, 0);
    step(1, 1, 0, 0, 4'hB, 0, 0);
    chk("y_1", ball_y, 1);
    step(1, 1, 0, 0, 4'h8, 0, 0);
    chk("y_clamp", ball_y, 0);
    // brick edges
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 6'h05, 0);
    chk("hit_mask", brick_alive, 'h3A);
    chk("hit_score", score, 2);
    step(1, 0, 0, 0, 0, 6'h00, 0);
    step(1, 0, 0, 0, 0, 6'h01, 0);
    step(1, 0, 0, 0, 0, 6'h00, 0);
    chk("dead_hit", score, 2);
    // win
    step(1, 0, 0, 0, 0, 6'h3A, 0);
    chk("win_mask", brick_alive, 0);
    chk("win_score", score, 6);
    step(1, 0, 0, 0, 0, 6'h00, 0);
    chk("win_state", state, 2);
    chk("win_flag", win, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4'h8, 4'd7, 0, 0);
    chk("over_frozen", ball_x, 485);
    // game_over priority and launch edge
    step(1, 0, 1, 0, 0, 0, 0);
    chk("reserve", state, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("launch_play", state, 1);
    step(1, 1, 1, 4'h8, 4'h8, 0, 1);
    chk("go_state", state, 2);
    chk("go_x", ball_x, 309);
    chk("go_win", win, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, 0);
    chk("held_launch", state, 2);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("press_state", state, 0);
    chk("press_score", score, 0);
    chk("press_mask", brick_alive, 'h3F);
    // randomized play
    for (int i = 0; i < 6000; i++) begin
      r  = ($urandom_range(0, 299) != 0);
      ft = ($urandom_range(0, 3) == 0);
      la = ($urandom_range(0, 29) == 0);
      g  = ($urandom_range(0, 199) == 0);
      step(r, ft, la, 4'($urandom), 4'($urandom),
           6'($urandom & $urandom & $urandom), g);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    done = 1;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
